delta_accum: RTL and testbench
==============================

Name: delta_accum

Overview:
- Reconstructs an 8-bit running value from a stream of 5-bit signed deltas. These are the nibble differences that the team's registered subtractor block produces.
- A frame is seeded by a start strobe and then integrates exactly FRAME_LEN valid deltas. It then pulses done and holds the result.
- Uses the standard tile pin set: ui_in, uo_out, uio_in, uio_out, uio_oe, ena, clk, rst_n.

Parameters:
- FRAME_LEN, 8, number of accepted deltas per frame. Legal range is 1..16.
- SATURATE, 1, overflow handling. 1 clamps the accumulator to 0/255; 0 wraps it mod 256.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- ui_in  input  8  [4:0] delta, two's complement, -16..15; [5] valid; [6] start; [7] abort.
- uo_out  output  8  accumulator value, unsigned 0..255, registered.
- uio_in  input  8  unused.
- uio_out  output  8  [7] done, [6] busy, [5] ovf (sticky), [4] 0, [3:0] accepted-delta count.
- uio_oe  output  8  constant 8'hFF.
- ena  input  1  ignored.

Behaviour:
- Interface: one clock (clk). Reset rst_n is asynchronous and active-low. All state is held in flops that clear on rst_n low, independent of clk.
- Reset values: acc=0, state=IDLE, cnt=0, ovf=0, done=0. Therefore uo_out=0 and uio_out=0. uio_oe is 8'hFF at all times, including during reset.
- States: IDLE, RUN, DONE. busy=1 only in RUN. done=1 only in DONE, a one-cycle pulse.
- Priority within a cycle: abort > start > valid.
- abort in any state:
  - next state is IDLE and cnt is set to 0;
  - acc and ovf hold their values.
- start in any state without abort:
  - acc <= {3'b000, ui_in[4:0]}, a zero-extended seed of 0..31;
  - cnt <= 0, ovf <= 0, next state RUN;
  - a start issued during RUN restarts the frame, and the valid bit in that cycle is ignored.
- IDLE: acc and cnt hold; valid is ignored.
- RUN with valid=1:
  - sum = acc + sign_extend(delta), computed in 10-bit signed;
  - if sum < 0 or sum > 255, set ovf=1 and write acc as the clamp (SATURATE=1) or sum[7:0] (SATURATE=0);
  - otherwise acc <= sum[7:0];
  - cnt <= cnt+1.
- Frame end: if cnt == FRAME_LEN-1 when a valid delta is accepted, the next state is DONE. cnt then reads FRAME_LEN (mod 16 on the 4-bit field).
- RUN with valid=0: no change. Gaps of any length are allowed.
- DONE: lasts one cycle. acc holds and next state is IDLE unless start or abort is present.
- Latency: a delta accepted at edge N appears on uo_out after edge N. done is high during the cycle following the edge that accepted the last delta.
- No combinational path from any input to any output.
- Reset asserted mid-frame clears everything immediately. After release the block sits in IDLE and ignores valid until a start arrives.

Test Plan:
1. Reset and idle:
   - Stimulus: hold rst_n=0, then release; pulse valid with delta=+5 without start.
   - Required: uo_out=0 and uio_out=0 throughout; acc stays 0.
2. Full frame (FRAME_LEN=8, SATURATE=1):
   - Stimulus: start with seed 10, then valid deltas +15,+15,-1,-16,+4,0,+2,-3.
   - Required: uo_out steps 25,40,39,23,27,27,29,26. done=1 for exactly one cycle after the 8th delta; uio_out[3:0]=8 at that point; busy=0 afterwards; uo_out holds 26.
3. Gaps and low saturation:
   - Stimulus: start seed 2; valid delta -16; two idle cycles; valid delta +3.
   - Required: acc=0 with ovf=1; acc unchanged during the gaps; then acc=3 with ovf still 1; cnt=2.
4. Wrap mode (SATURATE=0):
   - Stimulus: start seed 2, then delta -16.
   - Required: acc=242, ovf=1.
   - Stimulus: next start with seed 0.
   - Required: ovf clears to 0.
5. Abort and restart:
   - Stimulus: in RUN after 3 deltas (acc=40), assert abort together with start and valid.
   - Required: state IDLE, acc=40, cnt=0, no done pulse.
   - Stimulus: start seed 7 during RUN.
   - Required: acc=7, cnt=0, the same-cycle valid is ignored, busy=1.
6. Async reset mid-frame:
   - Stimulus: drop rst_n between clock edges after 5 deltas.
   - Required: outputs go to 0 before the next edge; after release, a valid delta without start leaves acc=0.

Source files
------------

// File: rtl/delta_accum.sv
// ============================================================================
// Module   : delta_accum
// Purpose  : Rebuilds an 8-bit running value from a stream of 5-bit signed
//            deltas, one FRAME_LEN-delta frame per start strobe.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module delta_accum #(
    parameter int FRAME_LEN = 8,
    parameter bit SATURATE  = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [3:0] C_LAST = 4'(FRAME_LEN - 1);

    state_t      r_state;
    logic [7:0]  r_acc;
    logic [3:0]  r_cnt;
    logic        r_ovf;
    logic        r_done;
    logic        r_busy;

    logic [4:0]        w_delta;
    logic              w_valid;
    logic              w_start;
    logic              w_abort;
    logic signed [9:0] w_sum;
    logic              w_out_of_range;
    logic [7:0]        w_next_acc;
    logic              w_unused;

    assign w_delta = ui_in[4:0];
    assign w_valid = ui_in[5];
    assign w_start = ui_in[6];
    assign w_abort = ui_in[7];
    assign w_unused = &{1'b0, uio_in, ena};

    // Ten bits hold the full range 0+(-16) .. 255+15 without loss.
    assign w_sum = $signed({2'b00, r_acc}) + $signed({{5{w_delta[4]}}, w_delta});
    assign w_out_of_range = w_sum[9] | w_sum[8];

    generate
        if (SATURATE) begin : g_saturate
            assign w_next_acc = !w_out_of_range ? w_sum[7:0] :
                                (w_sum[9] ? 8'h00 : 8'hFF);
        end else begin : g_wrap
            assign w_next_acc = w_sum[7:0];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_acc   <= 8'h00;
            r_cnt   <= 4'h0;
            r_ovf   <= 1'b0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_abort) begin
                r_state <= S_IDLE;
                r_cnt   <= 4'h0;
                r_busy  <= 1'b0;
            end else if (w_start) begin
                r_state <= S_RUN;
                r_acc   <= {3'b000, w_delta};
                r_cnt   <= 4'h0;
                r_ovf   <= 1'b0;
                r_busy  <= 1'b1;
            end else begin
                case (r_state)
                    S_RUN: begin
                        if (w_valid) begin
                            r_acc <= w_next_acc;
                            r_cnt <= r_cnt + 4'd1;
                            if (w_out_of_range) begin
                                r_ovf <= 1'b1;
                            end
                            if (r_cnt == C_LAST) begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                                r_busy  <= 1'b0;
                            end
                        end
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign uo_out  = r_acc;
    assign uio_out = {r_done, r_busy, r_ovf, 1'b0, r_cnt};
    assign uio_oe  = 8'hFF;

endmodule

`default_nettype wire

// File: tb/tb_delta_accum.sv
// ============================================================================
// Module   : tb_delta_accum
// Purpose  : Self-checking bench for delta_accum, saturating and wrapping
//            instances driven by the same directed stimulus.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_delta_accum;

    localparam int FRAME_LEN = 8;

    logic       clk;
    logic       rst_n;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic       ena;
    logic [7:0] uo_out_s, uio_out_s, uio_oe_s;
    logic [7:0] uo_out_w, uio_out_w, uio_oe_w;

    int n_assert = 0;
    int n_fail   = 0;

    delta_accum #(.FRAME_LEN(FRAME_LEN), .SATURATE(1'b1)) u_dut_sat (
        .clk(clk), .rst_n(rst_n), .ui_in(ui_in), .uo_out(uo_out_s),
        .uio_in(uio_in), .uio_out(uio_out_s), .uio_oe(uio_oe_s), .ena(ena)
    );

    delta_accum #(.FRAME_LEN(FRAME_LEN), .SATURATE(1'b0)) u_dut_wrap (
        .clk(clk), .rst_n(rst_n), .ui_in(ui_in), .uo_out(uo_out_w),
        .uio_in(uio_in), .uio_out(uio_out_w), .uio_oe(uio_oe_w), .ena(ena)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%02h) expected %0d (0x%02h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // Behavioural model: index 0 saturating, index 1 wrapping.
    // m_mode: 0 idle, 1 running, 2 frame just finished.
    int m_acc [2];
    int m_cnt [2];
    int m_ovf [2];
    int m_mode[2];

    always @(posedge clk or negedge rst_n) begin
        int d, s;
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_acc[i] = 0; m_cnt[i] = 0; m_ovf[i] = 0; m_mode[i] = 0;
            end else if (ui_in[7]) begin
                m_mode[i] = 0; m_cnt[i] = 0;
            end else if (ui_in[6]) begin
                m_acc[i] = int'(ui_in[4:0]); m_cnt[i] = 0; m_ovf[i] = 0; m_mode[i] = 1;
            end else if (m_mode[i] == 1 && ui_in[5]) begin
                d = int'(ui_in[4:0]);
                if (d >= 16) d = d - 32;
                s = m_acc[i] + d;
                if (s < 0 || s > 255) begin
                    m_ovf[i] = 1;
                    if (i == 0) m_acc[i] = (s < 0) ? 0 : 255;
                    else        m_acc[i] = (s + 256) % 256;
                end else begin
                    m_acc[i] = s;
                end
                m_cnt[i] = m_cnt[i] + 1;
                if (m_cnt[i] == FRAME_LEN) m_mode[i] = 2;
            end else if (m_mode[i] == 2) begin
                m_mode[i] = 0;
            end
        end
    end

    function automatic logic [7:0] exp_status(input int i);
        logic [3:0] c;
        c = 4'(m_cnt[i] % 16);
        return {m_mode[i] == 2, m_mode[i] == 1, m_ovf[i] != 0, 1'b0, c};
    endfunction

    always @(negedge clk) begin
        chk("sat.uo_out",   uo_out_s,  8'(m_acc[0]));
        chk("sat.uio_out",  uio_out_s, exp_status(0));
        chk("sat.uio_oe",   uio_oe_s,  8'hFF);
        chk("wrap.uo_out",  uo_out_w,  8'(m_acc[1]));
        chk("wrap.uio_out", uio_out_w, exp_status(1));
        chk("wrap.uio_oe",  uio_oe_w,  8'hFF);
    end

    function automatic logic [7:0] vec(input bit abort, input bit start,
                                       input bit valid, input int delta);
        logic [4:0] d;
        d = 5'(delta);
        return {abort, start, valid, d};
    endfunction

    task automatic step(input logic [7:0] v);
        ui_in = v;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int deltas[8] = '{15, 15, -1, -16, 4, 0, 2, -3};
        int steps [8] = '{25, 40, 39, 23, 27, 27, 29, 26};

        rst_n  = 1'b0;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        ena    = 1'b1;
        #2;
        chk("reset.uio_oe", uio_oe_s, 8'hFF);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 1: valid without start is ignored in idle
        step(vec(0, 0, 1, 5));
        step(vec(0, 0, 0, 0));
        chk("idle.acc", uo_out_s, 8'd0);
        chk("idle.status", uio_out_s, 8'h00);

        // 2: full frame, seed 10
        step(vec(0, 1, 0, 10));
        chk("frame.seed", uo_out_s, 8'd10);
        for (int k = 0; k < 8; k++) begin
            step(vec(0, 0, 1, deltas[k]));
            chk("frame.step", uo_out_s, 8'(steps[k]));
        end
        chk("frame.done_status", uio_out_s, 8'h88);
        step(vec(0, 0, 0, 0));
        chk("frame.after_done", uio_out_s, 8'h08);
        chk("frame.hold", uo_out_s, 8'd26);

        // 3: gaps and low saturation; wrap instance goes to 242
        step(vec(0, 1, 0, 2));
        step(vec(0, 0, 1, -16));
        chk("lowsat.acc", uo_out_s, 8'd0);
        chk("lowsat.status", uio_out_s, 8'h61);
        chk("wrap.acc", uo_out_w, 8'd242);
        step(vec(0, 0, 0, 0));
        step(vec(0, 0, 0, 0));
        chk("gap.acc", uo_out_s, 8'd0);
        step(vec(0, 0, 1, 3));
        chk("lowsat.acc2", uo_out_s, 8'd3);
        chk("lowsat.status2", uio_out_s, 8'h62);
        chk("wrap.acc2", uo_out_w, 8'd245);

        // 4: a new start clears ovf
        step(vec(0, 1, 0, 0));
        chk("wrap.ovf_clear", uio_out_w, 8'h40);

        // 5: abort beats start and valid
        step(vec(0, 1, 0, 10));
        step(vec(0, 0, 1, 15));
        step(vec(0, 0, 1, 15));
        step(vec(0, 0, 1, 0));
        chk("abort.pre", uo_out_s, 8'd40);
        step(vec(1, 1, 1, 5));
        chk("abort.acc", uo_out_s, 8'd40);
        chk("abort.status", uio_out_s, 8'h00);
        step(vec(0, 1, 0, 1));
        step(vec(0, 0, 1, 1));
        step(vec(0, 1, 1, 7));
        chk("restart.acc", uo_out_s, 8'd7);
        chk("restart.status", uio_out_s, 8'h40);
        step(vec(0, 0, 0, 0));

        // 6: asynchronous reset mid-frame
        step(vec(0, 1, 0, 0));
        for (int k = 0; k < 5; k++) step(vec(0, 0, 1, 1));
        chk("mid.acc", uo_out_s, 8'd5);
        ui_in = 8'h00;
        #1;
        rst_n = 1'b0;
        #1;
        chk("async.acc", uo_out_s, 8'd0);
        chk("async.status", uio_out_s, 8'h00);
        chk("async.oe", uio_oe_s, 8'hFF);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(vec(0, 0, 1, 5));
        step(vec(0, 0, 0, 0));
        chk("post_reset.acc", uo_out_s, 8'd0);
        chk("post_reset.status", uio_out_s, 8'h00);

        repeat (2) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
